lrn_addr_mapper_mc: RTL

- Next-generation address sequencer for the LRN normalisation stage; replaces the single-window read/process/write mapper.
- Read and write address generators are decoupled and run concurrently. They are linked by a credit counter, so reads can run ahead of divider results by up to MAX_OUTSTANDING elements.
- Sits between the feature-map SRAM, the LRN window/divider datapath and the layer controller.
- Supports runtime base addresses, an optional output padding border, and error flagging on protocol violations.

---
 rtl/lrn_mapper_pkg.sv | 27 ++
 rtl/lrn_idx_counter.sv | 65 ++++++
 rtl/lrn_addr_mapper_mc.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lrn_mapper_pkg.sv
// rtl/lrn_mapper_pkg.sv - shared state, width and index-bundle types for the LRN address mapper
package lrn_mapper_pkg;

  localparam int LRN_N_WIDTH        = 2;
  localparam int LRN_M_WIDTH        = 10;
  localparam int LRN_E_WIDTH        = 6;
  localparam int LRN_F_WIDTH        = 6;
  localparam int LRN_V_WIDTH        = 2;
  localparam int LRN_ADDR_BUS_WIDTH = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [LRN_ADDR_BUS_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic [LRN_N_WIDTH-1:0] i4;
    logic [LRN_M_WIDTH-1:0] i3;
    logic [LRN_E_WIDTH-1:0] i2;
    logic [LRN_F_WIDTH-1:0] i1;
  } idx_t;

endpackage

// File: rtl/lrn_idx_counter.sv
// rtl/lrn_idx_counter.sv - 4-level nested wrap counter over captured dims
// i4 (batch) is the fastest index and i1 the slowest; o_last flags the final element.
module lrn_idx_counter
  import lrn_mapper_pkg::*;
#(
  parameter int N_WIDTH = LRN_N_WIDTH,
  parameter int M_WIDTH = LRN_M_WIDTH,
  parameter int E_WIDTH = LRN_E_WIDTH,
  parameter int F_WIDTH = LRN_F_WIDTH
) (
  input  logic               core_clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic [F_WIDTH-1:0] i_d1,
  input  logic [E_WIDTH-1:0] i_d2,
  input  logic [M_WIDTH-1:0] i_d3,
  input  logic [N_WIDTH-1:0] i_d4,
  output logic [F_WIDTH-1:0] o_i1,
  output logic [E_WIDTH-1:0] o_i2,
  output logic [M_WIDTH-1:0] o_i3,
  output logic [N_WIDTH-1:0] o_i4,
  output logic               o_last
);

  logic w_wrap1, w_wrap2, w_wrap3, w_wrap4;

  assign w_wrap1 = (o_i1 == i_d1 - F_WIDTH'(1));
  assign w_wrap2 = (o_i2 == i_d2 - E_WIDTH'(1));
  assign w_wrap3 = (o_i3 == i_d3 - M_WIDTH'(1));
  assign w_wrap4 = (o_i4 == i_d4 - N_WIDTH'(1));
  assign o_last  = w_wrap1 & w_wrap2 & w_wrap3 & w_wrap4;

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      o_i1 <= '0;
      o_i2 <= '0;
      o_i3 <= '0;
      o_i4 <= '0;
    end else if (i_clear) begin
      o_i1 <= '0;
      o_i2 <= '0;
      o_i3 <= '0;
      o_i4 <= '0;
    end else if (i_en) begin
      if (w_wrap4) begin
        o_i4 <= '0;
        if (w_wrap3) begin
          o_i3 <= '0;
          if (w_wrap2) begin
            o_i2 <= '0;
            o_i1 <= w_wrap1 ? '0 : o_i1 + F_WIDTH'(1);
          end else begin
            o_i2 <= o_i2 + E_WIDTH'(1);
          end
        end else begin
          o_i3 <= o_i3 + M_WIDTH'(1);
        end
      end else begin
        o_i4 <= o_i4 + N_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/lrn_addr_mapper_mc.sv
// rtl/lrn_addr_mapper_mc.sv - decoupled read/write address sequencer for LRN with credit linking
// Optional stall_cycles counter enabled by defining MAPPER_STALL_CNT_EN.
module lrn_addr_mapper_mc
  import lrn_mapper_pkg::*;
#(
  parameter int N_WIDTH         = LRN_N_WIDTH,
  parameter int M_WIDTH         = LRN_M_WIDTH,
  parameter int E_WIDTH         = LRN_E_WIDTH,
  parameter int F_WIDTH         = LRN_F_WIDTH,
  parameter int V_WIDTH         = LRN_V_WIDTH,
  parameter int ADDR_BUS_WIDTH  = LRN_ADDR_BUS_WIDTH,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = 24
) (
  input  logic                      core_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N_WIDTH-1:0]        dim4,
  input  logic [M_WIDTH-1:0]        dim3,
  input  logic [E_WIDTH-1:0]        dim2,
  input  logic [F_WIDTH-1:0]        dim1,
  input  logic [V_WIDTH-1:0]        padding_num,
  input  logic [ADDR_BUS_WIDTH-1:0] rd_base,
  input  logic [ADDR_BUS_WIDTH-1:0] wr_base,
  input  logic                      r_ready,
  input  logic                      div_out_valid,
  output logic [ADDR_BUS_WIDTH-1:0] r_addr,
  output logic                      r_enable,
  output logic [ADDR_BUS_WIDTH-1:0] w_addr,
  output logic                      w_enable,
  output logic                      busy,
  output logic                      normalized_layer,
  output logic                      err
`ifdef MAPPER_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_cycles
`endif
);

  localparam int AW  = ADDR_BUS_WIDTH;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW1 = F_WIDTH + 1;
  localparam int EW1 = E_WIDTH + 1;

  if (MAX_OUTSTANDING < 1) begin : g_bad_max_outstanding
    $error("MAX_OUTSTANDING must be at least 1");
  end
  if (CNT_WIDTH < N_WIDTH + M_WIDTH + E_WIDTH + F_WIDTH) begin : g_bad_cnt_width
    $error("CNT_WIDTH too narrow for the element count");
  end

  state_t              r_state;
  logic [N_WIDTH-1:0]  r_d4;
  logic [M_WIDTH-1:0]  r_d3;
  logic [E_WIDTH-1:0]  r_d2;
  logic [F_WIDTH-1:0]  r_d1;
  logic [V_WIDTH-1:0]  r_pad;
  logic [AW-1:0]       r_rd_base, r_wr_base;
  logic [OW-1:0]       r_outstanding;

  logic w_accept, w_zero_dim, w_credit_ok, w_rd_issue, w_wr_issue;
  logic w_rd_last, w_wr_last;
  logic [F_WIDTH-1:0] w_i1, w_j1;
  logic [E_WIDTH-1:0] w_i2, w_j2;
  logic [M_WIDTH-1:0] w_i3, w_j3;
  logic [N_WIDTH-1:0] w_i4, w_j4;
  logic [FW1-1:0]     w_pd1;
  logic [EW1-1:0]     w_pd2;
  logic [AW-1:0]      w_rd_off, w_wr_off;

  assign w_accept    = start && (r_state == ST_IDLE);
  assign w_zero_dim  = (dim4 == '0) || (dim3 == '0) || (dim2 == '0) || (dim1 == '0);
  assign w_credit_ok = (r_outstanding < OW'(MAX_OUTSTANDING));
  assign w_rd_issue  = (r_state == ST_RUN) && r_ready && w_credit_ok;
  assign w_wr_issue  = div_out_valid && (r_outstanding != '0) &&
                       ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  lrn_idx_counter #(
    .N_WIDTH(N_WIDTH), .M_WIDTH(M_WIDTH), .E_WIDTH(E_WIDTH), .F_WIDTH(F_WIDTH)
  ) u_rd_idx (
    .core_clk(core_clk), .reset(reset), .i_clear(w_accept), .i_en(w_rd_issue),
    .i_d1(r_d1), .i_d2(r_d2), .i_d3(r_d3), .i_d4(r_d4),
    .o_i1(w_i1), .o_i2(w_i2), .o_i3(w_i3), .o_i4(w_i4), .o_last(w_rd_last)
  );

  lrn_idx_counter #(
    .N_WIDTH(N_WIDTH), .M_WIDTH(M_WIDTH), .E_WIDTH(E_WIDTH), .F_WIDTH(F_WIDTH)
  ) u_wr_idx (
    .core_clk(core_clk), .reset(reset), .i_clear(w_accept), .i_en(w_wr_issue),
    .i_d1(r_d1), .i_d2(r_d2), .i_d3(r_d3), .i_d4(r_d4),
    .o_i1(w_j1), .o_i2(w_j2), .o_i3(w_j3), .o_i4(w_j4), .o_last(w_wr_last)
  );

  // Padded plane extents are formed one bit wider so d+2p cannot overflow before the multiply.
  assign w_pd1 = {1'b0, r_d1} + FW1'({r_pad, 1'b0});
  assign w_pd2 = {1'b0, r_d2} + EW1'({r_pad, 1'b0});

  assign w_rd_off = AW'(w_i1) + AW'(r_d1) * (AW'(w_i2) + AW'(r_d2) *
                    (AW'(w_i3) + AW'(r_d3) * AW'(w_i4)));
  assign w_wr_off = AW'(w_j1) + AW'(r_pad) + AW'(w_pd1) * (AW'(w_j2) + AW'(r_pad) +
                    AW'(w_pd2) * (AW'(w_j3) + AW'(r_d3) * AW'(w_j4)));

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_d4             <= '0;
      r_d3             <= '0;
      r_d2             <= '0;
      r_d1             <= '0;
      r_pad            <= '0;
      r_rd_base        <= '0;
      r_wr_base        <= '0;
      r_outstanding    <= '0;
      r_addr           <= '0;
      r_enable         <= 1'b0;
      w_addr           <= '0;
      w_enable         <= 1'b0;
      normalized_layer <= 1'b0;
      err              <= 1'b0;
    end else begin
      r_enable         <= w_rd_issue;
      w_enable         <= w_wr_issue;
      normalized_layer <= (r_state == ST_DONE);
      if (w_rd_issue) r_addr <= r_rd_base + w_rd_off;
      if (w_wr_issue) w_addr <= r_wr_base + w_wr_off;

      // A stray result in the same cycle as an accepted start still counts as an error.
      if (w_accept) err <= 1'b0;
      if (div_out_valid && !w_wr_issue) err <= 1'b1;

      case ({w_rd_issue, w_wr_issue})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_d4      <= dim4;
            r_d3      <= dim3;
            r_d2      <= dim2;
            r_d1      <= dim1;
            r_pad     <= padding_num;
            r_rd_base <= rd_base;
            r_wr_base <= wr_base;
            r_state   <= w_zero_dim ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN:   if (w_rd_issue && w_rd_last) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_wr_issue && w_wr_last) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MAPPER_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall;

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (w_accept) begin
      r_stall <= '0;
    end else if ((r_state == ST_RUN) && !w_rd_issue && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule
